// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback end of the register-file write port.
//
// Holds the MEM/WB pipeline register. Non-load instructions write back the
// cycle after they are accepted, one per cycle. A load parks the stage in
// WAIT_LOAD until the data memory answers; the returned word is then aligned
// and sign/zero-extended before it is written. A load that never gets an
// answer is abandoned after LOAD_TIMEOUT wait cycles and flagged on load_err.
//
// Parameters:
//   LOAD_TIMEOUT  wait cycles before a load is abandoned (0 = wait forever)
//   TO_W          timeout counter width, 2**TO_W > LOAD_TIMEOUT
//
// Optional feature (compile-time macro WB_INSTRET_EN):
//   defined   -> instret counts retired instructions (64-bit, wraps)
//   undefined -> instret is tied to zero
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   mem_valid / mem_ready    handshake from MEM; ready only in IDLE
//   mem_reg_write            instruction writes rd
//   mem_memtoreg             instruction is a load
//   mem_rd                   destination register
//   mem_funct3               load width/sign (LB/LH/LW/LBU/LHU)
//   mem_result               ALU/link result, or load address for loads
//   dmem_rvalid, dmem_rdata  load response from data memory
//   reg_write, rd_wb, wd     register-file write port (registered)
//   load_err                 one-cycle pulse on load timeout
//   instret                  retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_reg_write,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write,
  output logic [4:0]  rd_wb,
  output logic [31:0] wd,
  output logic        load_err,
  output logic [63:0] instret
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  // Counter value seen in the last wait cycle before the load is abandoned.
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

  state_t          state, state_nx;
  logic [4:0]      ld_rd, ld_rd_nx;
  logic [2:0]      ld_f3, ld_f3_nx;
  logic [1:0]      ld_off, ld_off_nx;
  logic            ld_rw, ld_rw_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            reg_write_nx, load_err_nx;
  logic [4:0]      rd_wb_nx;
  logic [31:0]     wd_nx;
  logic            timeout_hit;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_ext;

  assign mem_ready = (state == IDLE);

  // A response in the final wait cycle still wins: dmem_rvalid is tested
  // before timeout_hit in the next-state logic.
  assign timeout_hit = (LOAD_TIMEOUT > 0) && (to_cnt == TO_LAST);

  // Load alignment and extension.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    ld_byte  = dmem_rdata[7:0];
    ld_half  = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext = dmem_rdata;
    case (ld_off)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    case (ld_f3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    ld_rd_nx     = ld_rd;
    ld_f3_nx     = ld_f3;
    ld_off_nx    = ld_off;
    ld_rw_nx     = ld_rw;
    to_cnt_nx    = to_cnt;
    reg_write_nx = 1'b0;
    load_err_nx  = 1'b0;
    rd_wb_nx     = rd_wb;
    wd_nx        = wd;

    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (mem_memtoreg) begin
            ld_rd_nx  = mem_rd;
            ld_f3_nx  = mem_funct3;
            ld_off_nx = mem_result[1:0];
            ld_rw_nx  = mem_reg_write;
            to_cnt_nx = '0;
            state_nx  = WAIT_LOAD;
          end else begin
            reg_write_nx = mem_reg_write && (mem_rd != 5'd0);
            rd_wb_nx     = mem_rd;
            wd_nx        = mem_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          reg_write_nx = ld_rw && (ld_rd != 5'd0);
          rd_wb_nx     = ld_rd;
          wd_nx        = load_ext;
          state_nx     = IDLE;
        end else if (timeout_hit) begin
          load_err_nx = 1'b1;
          state_nx    = IDLE;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      ld_rd     <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
      ld_rw     <= 1'b0;
      to_cnt    <= '0;
      reg_write <= 1'b0;
      load_err  <= 1'b0;
      rd_wb     <= '0;
      wd        <= '0;
    end else begin
      state     <= state_nx;
      ld_rd     <= ld_rd_nx;
      ld_f3     <= ld_f3_nx;
      ld_off    <= ld_off_nx;
      ld_rw     <= ld_rw_nx;
      to_cnt    <= to_cnt_nx;
      reg_write <= reg_write_nx;
      load_err  <= load_err_nx;
      rd_wb     <= rd_wb_nx;
      wd        <= wd_nx;
    end
  end

`ifdef WB_INSTRET_EN
  logic        retire;
  logic [63:0] instret_q;

  // Every accepted non-load retires at once; a load retires when it either
  // gets its data or is abandoned.
  assign retire = ((state == IDLE) && mem_valid && !mem_memtoreg) ||
                  ((state == WAIT_LOAD) && (dmem_rvalid || timeout_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage (LOAD_TIMEOUT = 4).
// Each driven instruction pushes its expected writeback together with the
// negedge index at which it must be visible; a negedge monitor pops and
// compares, and flags any pulse that nothing was expected for.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int TO = 4;

  typedef struct {
    int          due;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        err;
    logic [63:0] ret;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, mem_reg_write, mem_memtoreg;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_write, load_err;
  logic [4:0]  rd_wb;
  logic [31:0] wd;
  logic [63:0] instret;

  int          total = 0;
  int          bad   = 0;
  int          nidx  = 0;
  ev_t         sb[$];
  logic [63:0] retired = '0;
  logic [4:0]  exp_rd  = '0;
  logic [31:0] exp_wd  = '0;

  wb_stage #(.LOAD_TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_result(mem_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_write(reg_write), .rd_wb(rd_wb), .wd(wd),
    .load_err(load_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected writeback produced by the clock edge that ends the current cycle.
  task automatic push_ev(input logic rw, input logic [4:0] rd,
                         input logic [31:0] data, input logic err);
    ev_t e;
    if (!err) begin
      exp_rd = rd;
      exp_wd = data;
    end
    retired++;
    e.due = nidx + 2;
    e.rw  = rw && (rd != 5'd0) && !err;
    e.rd  = exp_rd;
    e.wd  = exp_wd;
    e.err = err;
`ifdef WB_INSTRET_EN
    e.ret = retired;
`else
    e.ret = '0;
`endif
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    nidx++;
    if (sb.size() > 0 && sb[0].due == nidx) begin
      ev_t e;
      e = sb.pop_front();
      check("reg_write", {63'd0, reg_write}, {63'd0, e.rw});
      check("rd_wb", {59'd0, rd_wb}, {59'd0, e.rd});
      check("wd", {32'd0, wd}, {32'd0, e.wd});
      check("load_err", {63'd0, load_err}, {63'd0, e.err});
      check("instret", instret, e.ret);
    end else if (reg_write || load_err) begin
      check("spurious_pulse", {62'd0, reg_write, load_err}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-load instruction; leaves mem_valid high so calls can run back to back.
  task automatic alu(input logic [4:0] rd, input logic [31:0] res,
                     input logic rw);
    mem_valid     = 1'b1;
    mem_memtoreg  = 1'b0;
    mem_reg_write = rw;
    mem_rd        = rd;
    mem_result    = res;
    check("ready_alu", {63'd0, mem_ready}, 64'd1);
    push_ev(rw, rd, res, 1'b0);
    tick();
  endtask

  // Load answered in wait cycle 'lat'; 'stray' also pulses dmem_rvalid with
  // garbage in the accept cycle, which must not be consumed.
  task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                      input logic [1:0] off, input int lat,
                      input logic [31:0] data, input logic [31:0] exp,
                      input logic stray);
    mem_valid     = 1'b1;
    mem_memtoreg  = 1'b1;
    mem_reg_write = 1'b1;
    mem_rd        = rd;
    mem_funct3    = f3;
    mem_result    = {30'h1000_0000, off};
    dmem_rvalid   = stray;
    dmem_rdata    = ~data;
    tick();
    mem_valid    = 1'b0;
    mem_memtoreg = 1'b0;
    dmem_rvalid  = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("ready_wait", {63'd0, mem_ready}, 64'd0);
      tick();
    end
    check("ready_wait", {63'd0, mem_ready}, 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    push_ev(1'b1, rd, exp, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    check("ready_after_load", {63'd0, mem_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_memtoreg = 1'b0;
    mem_rd = '0; mem_funct3 = '0; mem_result = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    #1;
    check("rst_reg_write", {63'd0, reg_write}, 64'd0);
    check("rst_rd_wb", {59'd0, rd_wb}, 64'd0);
    check("rst_wd", {32'd0, wd}, 64'd0);
    check("rst_load_err", {63'd0, load_err}, 64'd0);
    check("rst_instret", instret, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ready_idle", {63'd0, mem_ready}, 64'd1);

    // Back-to-back ALU writebacks, one per cycle, rd=0 suppressed.
    alu(5'd5, 32'h11, 1'b1);
    alu(5'd6, 32'h22, 1'b1);
    alu(5'd0, 32'h33, 1'b1);
    mem_valid = 1'b0;
    // Store-like instruction: retires without writing.
    alu(5'd12, 32'hDEAD, 1'b0);
    mem_valid = 1'b0;
    tick();

    // Load latency and extension matrix.
    load(5'd7,  3'b000, 2'd3, 3, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0);
    load(5'd8,  3'b101, 2'd2, 1, 32'h8001_7F02, 32'h0000_8001, 1'b0);
    load(5'd10, 3'b001, 2'd0, 2, 32'h8001_7F02, 32'h0000_7F02, 1'b1);
    load(5'd11, 3'b100, 2'd1, 1, 32'h8001_7F02, 32'h0000_007F, 1'b0);
    load(5'd13, 3'b010, 2'd3, 2, 32'h8001_7F02, 32'h8001_7F02, 1'b0);
    load(5'd14, 3'b001, 2'd2, 1, 32'h8001_7F02, 32'hFFFF_8001, 1'b0);
    load(5'd15, 3'b111, 2'd1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    // Response in the last allowed wait cycle beats the timeout.
    load(5'd16, 3'b000, 2'd0, TO, 32'h0000_0085, 32'hFFFF_FF85, 1'b0);
    // Load to x0: no write enable, data still visible.
    load(5'd0,  3'b010, 2'd0, 1, 32'h1234_5678, 32'h1234_5678, 1'b0);

    // Timeout: LW rd=9 never answered.
    mem_valid = 1'b1; mem_memtoreg = 1'b1; mem_reg_write = 1'b1;
    mem_rd = 5'd9; mem_funct3 = 3'b010; mem_result = 32'h2000_0000;
    tick();
    mem_valid = 1'b0; mem_memtoreg = 1'b0;
    for (int k = 1; k < TO; k++) begin
      check("ready_to_wait", {63'd0, mem_ready}, 64'd0);
      tick();
    end
    check("ready_to_wait", {63'd0, mem_ready}, 64'd0);
    push_ev(1'b0, 5'd9, 32'd0, 1'b1);
    tick();
    check("ready_after_to", {63'd0, mem_ready}, 64'd1);
    // Stray response in IDLE is ignored (monitor flags any pulse).
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_rvalid = 1'b0;
    repeat (3) tick();
    check("sb_drain_pre_rst", sb.size(), 64'd0);

    // Reset in the middle of a load.
    mem_valid = 1'b1; mem_memtoreg = 1'b1; mem_reg_write = 1'b1;
    mem_rd = 5'd20; mem_funct3 = 3'b010; mem_result = 32'h3000_0000;
    tick();
    mem_valid = 1'b0; mem_memtoreg = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_reg_write", {63'd0, reg_write}, 64'd0);
    check("midrst_rd_wb", {59'd0, rd_wb}, 64'd0);
    check("midrst_wd", {32'd0, wd}, 64'd0);
    check("midrst_load_err", {63'd0, load_err}, 64'd0);
    check("midrst_instret", instret, 64'd0);
    retired = '0; exp_rd = '0; exp_wd = '0;
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    check("ready_post_rst", {63'd0, mem_ready}, 64'd1);
    alu(5'd3, 32'h44, 1'b1);
    mem_valid = 1'b0;
    repeat (4) tick();

    check("sb_drain", sb.size(), 64'd0);
`ifdef WB_INSTRET_EN
    check("instret_final", instret, retired);
`else
    check("instret_final", instret, 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
